// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit: 32 shift-add or restoring-divide steps,
// result written to HI/LO on entry to DONE.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_b_zero;
    logic [31:0] r_a;
    logic [31:0] r_y;
    logic [63:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_div_zero;
    logic        r_busy;
    logic        r_done;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_a_neg = op[0] & A[31];
    assign w_b_neg = op[0] & B[31];
    assign w_a_mag = w_a_neg ? (~A + 32'd1) : A;
    assign w_b_mag = w_b_neg ? (~B + 32'd1) : B;

    // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_y} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: r_acc = {partial remainder, dividend/quotient}, shifted left each step.
    assign w_div_diff = r_acc[63:31] - {1'b0, r_y};
    assign w_div_next = w_div_diff[32] ? {r_acc[62:31], r_acc[30:0], 1'b0}
                                       : {w_div_diff[31:0], r_acc[30:0], 1'b1};

    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;
    assign w_prod     = r_neg_q ? (~w_acc_next + 64'd1) : w_acc_next;
    assign w_quo      = r_neg_q ? (~w_acc_next[31:0] + 32'd1) : w_acc_next[31:0];
    assign w_rem      = r_neg_r ? (~w_acc_next[63:32] + 32'd1) : w_acc_next[63:32];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_b_zero   <= 1'b0;
            r_a        <= 32'd0;
            r_y        <= 32'd0;
            r_acc      <= 64'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_cnt    <= 5'd0;
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_b_zero <= (B == 32'd0);
                        r_a      <= A;
                        if (op[1]) begin
                            r_acc <= {32'd0, w_a_mag};
                            r_y   <= w_b_mag;
                        end else begin
                            r_acc <= {32'd0, w_b_mag};
                            r_y   <= w_a_mag;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_is_div && r_b_zero) begin
                            r_hi       <= r_a;
                            r_lo       <= 32'hFFFF_FFFF;
                            r_div_zero <= 1'b1;
                        end else if (r_is_div) begin
                            r_hi       <= w_rem;
                            r_lo       <= w_quo;
                            r_div_zero <= 1'b0;
                        end else begin
                            r_hi       <= w_prod[63:32];
                            r_lo       <= w_prod[31:0];
                            r_div_zero <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of operations plus hand-written
// sequences for start hold-off, reset abort and reset/start priority.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation; operands are scrambled right after the start edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r_hi, output logic [31:0] r_lo, output logic r_dz,
                          output int busy_n, output int done_at, output int done_n);
        busy_n = 0; done_at = -1; done_n = 0;
        r_hi = 32'hDEAD_BEEF; r_lo = 32'hDEAD_BEEF; r_dz = 1'bx;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; A = ~a; B = b ^ 32'h5A5A_A5A5; op = ~o;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = k;
                r_hi = hi; r_lo = lo; r_dz = div_zero;
            end
        end
    endtask

    vec_t vecs[15];

    initial begin
        logic [31:0] g_hi, g_lo, h1, l1, h2, l2, a2, b2;
        logic        g_dz;
        int          bn, da, dn, d1_at, d2_at, cnt;

        vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2]  = '{MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0,         32'd15,        1'b0};
        vecs[3]  = '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[4]  = '{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
        vecs[7]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        vecs[8]  = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{DIVU,  32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 1'b0};
        vecs[11] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
        vecs[12] = '{MULT,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[13] = '{DIVU,  32'h8000_0000, 32'h8000_0000, 32'd0,         32'd1,         1'b0};
        vecs[14] = '{MULTU, 32'h1234_5678, 32'd16,        32'h1,         32'h2345_6780, 1'b0};

        reset = 1'b1; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset hi/lo", {hi, lo}, 64'd0);
        chk("reset div_zero", {63'd0, div_zero}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, g_hi, g_lo, g_dz, bn, da, dn);
            chk($sformatf("vec%0d hi", i), {32'd0, g_hi}, {32'd0, vecs[i].hi});
            chk($sformatf("vec%0d lo", i), {32'd0, g_lo}, {32'd0, vecs[i].lo});
            chk($sformatf("vec%0d div_zero", i), {63'd0, g_dz}, {63'd0, vecs[i].dz});
            chk($sformatf("vec%0d busy cycles", i), 64'(bn), 64'd32);
            chk($sformatf("vec%0d done cycle", i), 64'(da), 64'd33);
            chk($sformatf("vec%0d done pulses", i), 64'(dn), 64'd1);
        end

        // Idle hold: result registers ignore operand traffic while idle.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            A = 32'h1111_1111 * (k + 1); B = ~A; op = 2'(k);
        end
        chk("idle hold hi/lo", {hi, lo}, {32'h1, 32'h2345_6780});

        // Start held for 40 cycles with moving operands.
        dn = 0; d1_at = -1; d2_at = -1; h1 = 0; l1 = 0; h2 = 0; l2 = 0; a2 = 0; b2 = 1;
        @(negedge clk);
        start = 1'b1; op = DIVU; A = 32'd10; B = 32'd3;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (dn == 1) begin d1_at = k; h1 = hi; l1 = lo; end
                else begin d2_at = k; h2 = hi; l2 = lo; end
            end
            if (k == 34) chk("hold start idle gap busy", {63'd0, busy}, 64'd0);
            if (k == 35) chk("hold start second accept", {63'd0, busy}, 64'd1);
            if (k < 40) begin
                A = 32'd1000 + 32'(k * 3); B = 32'd7 + 32'(k);
                if (k == 34) begin a2 = A; b2 = B; end
            end else begin
                start = 1'b0;
            end
        end
        chk("hold start first done cycle", 64'(d1_at), 64'd33);
        chk("hold start first result", {h1, l1}, {32'd1, 32'd3});
        chk("hold start done count", 64'(dn), 64'd2);
        chk("hold start second done cycle", 64'(d2_at), 64'd67);
        chk("hold start second result", {h2, l2}, {a2 % b2, a2 / b2});

        // Reset during the 10th RUN cycle aborts the operation.
        @(negedge clk);
        start = 1'b1; op = MULTU; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        cnt = 0;
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 10) reset = 1'b1;
            if (k == 11) begin
                reset = 1'b0;
                chk("abort busy", {63'd0, busy}, 64'd0);
                chk("abort hi/lo", {hi, lo}, 64'd0);
                chk("abort div_zero", {63'd0, div_zero}, 64'd0);
            end
            if (k >= 11 && done) cnt++;
        end
        chk("abort no done", 64'(cnt), 64'd0);

        // Reset wins over a simultaneous start, and the start is not remembered.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = MULTU; A = 32'd2; B = 32'd3;
        @(negedge clk);
        chk("reset+start busy", {63'd0, busy}, 64'd0);
        reset = 1'b0; start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy || done) cnt++;
        end
        chk("reset+start no activity", 64'(cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
